key_debounce: RTL and testbench
===============================

Name: key_debounce

Overview:
- Board-input conditioning stage in front of the proj_agh core. Synchronises the raw push-button vector (KEY, active-low on the board) into the 50 MHz domain and debounces each bit independently.
- Produces per-key stable levels, one-cycle press/release strobes and an optional long-press strobe.
- The top level consumes these instead of raw KEY bits for user commands and the user reset request.

Parameters:
- WIDTH, 2, number of independent keys.
- DEBOUNCE_CYCLES, 1000000, consecutive stable clk cycles required to accept a change (20 ms at 50 MHz); legal range >= 2.
- LONG_CYCLES, 100000000, cycles a key must remain accepted-pressed before key_long fires; 0 disables key_long.
- ACTIVE_LOW, 1, 1: raw 0 means pressed; 0: raw 1 means pressed.

Ports:
- clk, input, 1, system clock (FPGA_CLK_50 domain).
- rst, input, 1, synchronous, active-high reset.
- key_raw, input, WIDTH, asynchronous raw button pins.
- key_level, output, WIDTH, debounced state, 1 = pressed.
- key_press, output, WIDTH, 1-cycle pulse on accepted press.
- key_release, output, WIDTH, 1-cycle pulse on accepted release.
- key_long, output, WIDTH, 1-cycle pulse when held LONG_CYCLES after acceptance.

Behaviour:
- Sync: two flops per bit (sync1, sync2). On rst, both load the released raw value (~ACTIVE_LOW is wrong; use ACTIVE_LOW ? 1 : 0), so that reset never produces a fake press. p = sync2 normalised to 1 = pressed.
- Per-key FSM, state plus counter of width $clog2(max(DEBOUNCE_CYCLES, LONG_CYCLES) + 1):
  - IDLE: if p, go to PRESS_WAIT with cnt=1; otherwise stay.
  - PRESS_WAIT:
    - if !p, go to IDLE with cnt=0; no pulse.
    - else if cnt == DEBOUNCE_CYCLES-1, go to PRESSED, set key_level=1, pulse key_press, cnt=0.
    - else cnt++.
  - PRESSED:
    - if !p, go to REL_WAIT with cnt=1.
    - else if LONG_CYCLES != 0 and the long pulse is not yet fired: cnt++; when cnt == LONG_CYCLES-1, pulse key_long and set the fired flag. The counter saturates afterwards.
  - REL_WAIT:
    - if p, return to PRESSED. Keep the fired flag; restart the long count at 0 only if it has not fired.
    - else if cnt == DEBOUNCE_CYCLES-1, go to IDLE, set key_level=0, pulse key_release, clear the fired flag.
    - else cnt++.
- Latency: for a clean edge first sampled into sync1 at edge k, key_level and the strobe become visible after edge k+DEBOUNCE_CYCLES+1. The same applies to release.
- Glitch rule: any bounce shorter than DEBOUNCE_CYCLES consecutive cycles produces no output change and no pulse.
- Strobes: key_press, key_release and key_long are registered and high for exactly one cycle. key_long fires at most once per press. key_press and key_release are never high together for the same key.
- Keys are fully independent. Simultaneous events on different bits produce simultaneous pulses on those bits.
- Reset values: all outputs 0; all FSMs IDLE; cnt=0; fired flags cleared.
- Reset mid-operation: outputs drop to 0 on the next edge with rst=1, and no release pulse is generated. A key still held after rst deasserts is re-debounced from scratch. Its key_press fires DEBOUNCE_CYCLES+1 edges after it first reaches sync1 post-reset.
- Counter overflow: impossible by construction, because the compares stop counting.

Test Plan:
All scenarios use DEBOUNCE_CYCLES=4, LONG_CYCLES=10, WIDTH=2, ACTIVE_LOW=1.
1. Reset for 3 cycles, key_raw=2'b11 held 20 cycles -> all outputs 0 throughout, no pulses.
2. key_raw[0] goes to 0 just before edge 0 and stays low -> key_level[0]=1 and key_press[0]=1 after edge 5; key_press[0]=0 after edge 6; key[1] unaffected.
3. Bounce on key 0: 0 for 2 cycles, 1 for 1 cycle, 0 for 3 cycles, then 1 -> no key_level or key_press activity at any time.
4. Key 0 held pressed -> key_long[0] pulses once, 10 cycles after the key_press edge. Then release cleanly -> key_release[0] pulses 5 edges after the raw rise, and key_level[0] returns to 0.
5. Both keys pressed on the same cycle -> key_press=2'b11 on the same cycle, single pulse each.
6. Key 0 accepted pressed, then rst asserted for 1 cycle while held -> key_level=0 with no release pulse. key_press[0] fires again 5 edges after the first post-reset sample.

Source files
------------

// File: rtl/key_debounce.sv
// Push-button conditioning: two-flop synchroniser per key followed by an
// independent debounce FSM per key that yields a stable level, one-cycle
// press/release strobes and an optional one-shot long-press strobe.
module key_debounce #(
    parameter int WIDTH           = 2,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int LONG_CYCLES     = 100000000,
    parameter bit ACTIVE_LOW      = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] key_raw,
    output logic [WIDTH-1:0] key_level,
    output logic [WIDTH-1:0] key_press,
    output logic [WIDTH-1:0] key_release,
    output logic [WIDTH-1:0] key_long
);

    // One counter serves both the debounce window and the long-press timer,
    // so it is sized for whichever of the two is larger.
    localparam int MAX_CYCLES = (DEBOUNCE_CYCLES > LONG_CYCLES) ? DEBOUNCE_CYCLES : LONG_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES + 1);

    localparam logic [CW-1:0] DB_LAST   = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] LONG_LAST = CW'((LONG_CYCLES == 0) ? 0 : LONG_CYCLES - 1);

    // Raw pin level that corresponds to a released key.
    localparam logic [WIDTH-1:0] RAW_IDLE = {WIDTH{ACTIVE_LOW}};

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        PRESS_WAIT = 2'd1,
        PRESSED    = 2'd2,
        REL_WAIT   = 2'd3
    } state_t;

    logic [WIDTH-1:0] sync1;
    logic [WIDTH-1:0] sync2;
    logic [WIDTH-1:0] pressed;

    state_t           state      [WIDTH];
    state_t           state_next [WIDTH];
    logic [CW-1:0]    cnt        [WIDTH];
    logic [CW-1:0]    cnt_next   [WIDTH];
    logic [WIDTH-1:0] fired;
    logic [WIDTH-1:0] fired_next;
    logic [WIDTH-1:0] level_next;
    logic [WIDTH-1:0] press_next;
    logic [WIDTH-1:0] release_next;
    logic [WIDTH-1:0] long_next;

    // Two-flop synchroniser; reset loads the released level so that leaving
    // reset can never look like a press.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= RAW_IDLE;
            sync2 <= RAW_IDLE;
        end else begin
            sync1 <= key_raw;
            sync2 <= sync1;
        end
    end

    // Normalise polarity: 1 means the key is physically pressed.
    assign pressed = sync2 ^ RAW_IDLE;

    // Per-key state, counter, fired flag and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < WIDTH; i++) begin
                state[i] <= IDLE;
                cnt[i]   <= '0;
            end
            fired       <= '0;
            key_level   <= '0;
            key_press   <= '0;
            key_release <= '0;
            key_long    <= '0;
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                state[i] <= state_next[i];
                cnt[i]   <= cnt_next[i];
            end
            fired       <= fired_next;
            key_level   <= level_next;
            key_press   <= press_next;
            key_release <= release_next;
            key_long    <= long_next;
        end
    end

    // Next-state and strobe decode for every key independently.
    always_comb begin
        for (int i = 0; i < WIDTH; i++) begin
            state_next[i]   = state[i];
            cnt_next[i]     = cnt[i];
            fired_next[i]   = fired[i];
            level_next[i]   = key_level[i];
            press_next[i]   = 1'b0;
            release_next[i] = 1'b0;
            long_next[i]    = 1'b0;

            case (state[i])
                IDLE: begin
                    if (pressed[i]) begin
                        state_next[i] = PRESS_WAIT;
                        cnt_next[i]   = CW'(1);
                    end
                end

                PRESS_WAIT: begin
                    if (!pressed[i]) begin
                        // Bounce: abandon the attempt silently.
                        state_next[i] = IDLE;
                        cnt_next[i]   = '0;
                    end else if (cnt[i] == DB_LAST) begin
                        state_next[i] = PRESSED;
                        level_next[i] = 1'b1;
                        press_next[i] = 1'b1;
                        cnt_next[i]   = '0;
                    end else begin
                        cnt_next[i] = cnt[i] + CW'(1);
                    end
                end

                PRESSED: begin
                    if (!pressed[i]) begin
                        state_next[i] = REL_WAIT;
                        cnt_next[i]   = CW'(1);
                    end else if ((LONG_CYCLES != 0) && !fired[i]) begin
                        // Counting stops once the long strobe has fired.
                        if (cnt[i] == LONG_LAST) begin
                            long_next[i]  = 1'b1;
                            fired_next[i] = 1'b1;
                        end else begin
                            cnt_next[i] = cnt[i] + CW'(1);
                        end
                    end
                end

                REL_WAIT: begin
                    if (pressed[i]) begin
                        // Release bounce: back to held, long timing restarts
                        // unless it has already fired for this press.
                        state_next[i] = PRESSED;
                        if (!fired[i]) begin
                            cnt_next[i] = '0;
                        end
                    end else if (cnt[i] == DB_LAST) begin
                        state_next[i]   = IDLE;
                        level_next[i]   = 1'b0;
                        release_next[i] = 1'b1;
                        fired_next[i]   = 1'b0;
                        cnt_next[i]     = '0;
                    end else begin
                        cnt_next[i] = cnt[i] + CW'(1);
                    end
                end

                default: begin
                    state_next[i] = IDLE;
                    cnt_next[i]   = '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_key_debounce.sv
// Bench for key_debounce: directed scenarios followed by random bouncing
// key traffic, all checked every cycle against a sample-history model.
module tb_key_debounce;

    localparam int W  = 2;
    localparam int D  = 4;
    localparam int L  = 10;

    localparam logic [31:0] DMASK = (32'd1 << D) - 32'd1;
    localparam logic [31:0] LMASK = (32'd1 << (L + 1)) - 32'd1;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] key_raw;
    logic [W-1:0] key_level;
    logic [W-1:0] key_press;
    logic [W-1:0] key_release;
    logic [W-1:0] key_long;

    int errors = 0;
    int checks = 0;

    key_debounce #(
        .WIDTH(W),
        .DEBOUNCE_CYCLES(D),
        .LONG_CYCLES(L),
        .ACTIVE_LOW(1'b1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .key_raw(key_raw),
        .key_level(key_level),
        .key_press(key_press),
        .key_release(key_release),
        .key_long(key_long)
    );

    always #5 clk = ~clk;

    // Reference model: the pressed-ness of every sample the debouncer
    // consumes is kept as a bit history; a level change is accepted when the
    // last D consumed samples all disagree with the current level, and a long
    // press when L+1 consecutive pressed samples fit inside the accepted hold.
    logic [W-1:0] m_d1, m_d2;
    logic [31:0]  hist [W];
    logic [W-1:0] m_level, m_press, m_rel, m_long, m_fired;
    int           acc_edge [W];
    int           now = 0;

    task automatic model_edge();
        now++;
        m_press = '0;
        m_rel   = '0;
        m_long  = '0;
        if (rst) begin
            m_d1    = '0;
            m_d2    = '0;
            m_level = '0;
            m_fired = '0;
            for (int k = 0; k < W; k++) hist[k] = '0;
        end else begin
            for (int k = 0; k < W; k++) hist[k] = {hist[k][30:0], m_d2[k]};
            m_d2 = m_d1;
            m_d1 = ~key_raw;
            for (int k = 0; k < W; k++) begin
                if (!m_level[k]) begin
                    if ((hist[k] & DMASK) == DMASK) begin
                        m_level[k]  = 1'b1;
                        m_press[k]  = 1'b1;
                        acc_edge[k] = now;
                    end
                end else if ((hist[k] & DMASK) == 32'd0) begin
                    m_level[k] = 1'b0;
                    m_rel[k]   = 1'b1;
                    m_fired[k] = 1'b0;
                end else if (!m_fired[k] && (now - acc_edge[k] >= L) &&
                             ((hist[k] & LMASK) == LMASK)) begin
                    m_long[k]  = 1'b1;
                    m_fired[k] = 1'b1;
                end
            end
        end
    endtask

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s t=%0d observed=%b expected=%b", tag, now, obs, exp);
        end
    endtask

    // Advance one clock: model the edge, let the DUT take it, sample #1 later.
    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
        chk("level",   key_level,   m_level);
        chk("press",   key_press,   m_press);
        chk("release", key_release, m_rel);
        chk("long",    key_long,    m_long);
    endtask

    int run_left [W];
    logic [W-1:0] cur;

    initial begin
        int bounce [12];
        bounce = '{0, 0, 1, 0, 0, 0, 1, 1, 1, 1, 1, 1};
        m_d1 = '0; m_d2 = '0; m_level = '0; m_fired = '0;
        m_press = '0; m_rel = '0; m_long = '0;
        for (int k = 0; k < W; k++) begin
            hist[k] = '0;
            acc_edge[k] = 0;
        end

        // Reset, then idle keys released for 20 cycles.
        rst = 1'b1;
        key_raw = 2'b11;
        for (int i = 0; i < 3; i++) tick();
        chk("rst_level", key_level, 2'b00);
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("idle_press", key_press, 2'b00);
        end

        // Clean press of key 0: sampled at edge 0, accepted after edge 5.
        key_raw = 2'b10;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("pre_accept_level", key_level, 2'b00);
        end
        tick();
        chk("accept_level", key_level, 2'b01);
        chk("accept_press", key_press, 2'b01);
        tick();
        chk("press_one_cycle", key_press, 2'b00);

        // Keep holding: long strobe 10 edges after the press edge (edge 15).
        for (int i = 7; i < 15; i++) begin
            tick();
            chk("long_early", key_long, 2'b00);
        end
        tick();
        chk("long_fire", key_long, 2'b01);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("long_once", key_long, 2'b00);
        end

        // Clean release: release strobe 5 edges after the raw rise.
        key_raw = 2'b11;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("rel_hold_level", key_level, 2'b01);
        end
        tick();
        chk("release_pulse", key_release, 2'b01);
        chk("release_level", key_level, 2'b00);
        for (int i = 0; i < 4; i++) tick();

        // Bounce shorter than the debounce window: nothing happens.
        for (int i = 0; i < 12; i++) begin
            key_raw = {1'b1, bounce[i][0]};
            tick();
            chk("bounce_level", key_level, 2'b00);
            chk("bounce_press", key_press, 2'b00);
        end
        for (int i = 0; i < 4; i++) tick();

        // Both keys pressed together.
        key_raw = 2'b00;
        for (int i = 0; i < 5; i++) tick();
        tick();
        chk("dual_press", key_press, 2'b11);
        tick();
        chk("dual_press_end", key_press, 2'b00);
        for (int i = 0; i < 12; i++) tick();
        key_raw = 2'b11;
        for (int i = 0; i < 8; i++) tick();

        // Reset while key 0 is held: no release, then re-debounce.
        key_raw = 2'b10;
        for (int i = 0; i < 6; i++) tick();
        chk("pre_rst_level", key_level, 2'b01);
        rst = 1'b1;
        tick();
        chk("rst_drop_level", key_level, 2'b00);
        chk("rst_no_release", key_release, 2'b00);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("post_rst_wait", key_press, 2'b00);
        end
        tick();
        chk("post_rst_press", key_press, 2'b01);
        key_raw = 2'b11;
        for (int i = 0; i < 8; i++) tick();

        // Random bouncing traffic with occasional resets.
        cur = '0;
        for (int k = 0; k < W; k++) run_left[k] = 0;
        for (int n = 0; n < 1500; n++) begin
            for (int k = 0; k < W; k++) begin
                if (run_left[k] == 0) begin
                    cur[k] = ~cur[k];
                    run_left[k] = int'($urandom_range(1, 16));
                end
                run_left[k]--;
            end
            key_raw = ~cur;
            rst = ($urandom_range(0, 249) == 0);
            tick();
        end
        rst = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
